// File: rtl/write_back_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : write_back_buffer_pkg                                      |
// | Brief   : Result-source and load-size encodings shared with decode.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package write_back_buffer_pkg;

  typedef enum logic [1:0] {
    WB_SEL_ALU     = 2'd0,
    WB_SEL_MEM     = 2'd1,
    WB_SEL_LINK    = 2'd2,
    WB_SEL_ALU_ALT = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    LD_BYTE     = 2'd0,
    LD_HALF     = 2'd1,
    LD_WORD     = 2'd2,
    LD_WORD_ALT = 2'd3
  } load_size_e;

endpackage : write_back_buffer_pkg
`default_nettype wire

// File: rtl/write_back_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : write_back_buffer_if                                       |
// | Brief   : MEM/WB result, register-file port and forwarding query.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface write_back_buffer_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH    = 32
);
  logic                      valid_in;
  logic                      ready_out;
  logic [DATA_WIDTH-1:0]     alu_data_in;
  logic [DATA_WIDTH-1:0]     mem_data_in;
  logic [DATA_WIDTH-1:0]     link_data_in;
  logic [1:0]                wb_sel_in;
  logic [1:0]                load_size_in;
  logic                      load_unsigned_in;
  logic [1:0]                byte_offset_in;
  logic                      w_reg_en_in;
  logic [REG_ADDR_WIDTH-1:0] w_reg_addr_in;
  logic                      reg_wr_en_out;
  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_out;
  logic [DATA_WIDTH-1:0]     reg_data_out;
  logic                      rf_ready_in;
  logic [REG_ADDR_WIDTH-1:0] query_addr_in;
  logic                      hit_out;
  logic [DATA_WIDTH-1:0]     hit_data_out;
  logic [COUNT_WIDTH-1:0]    retired_count_out;

  modport master (
    output valid_in, alu_data_in, mem_data_in, link_data_in, wb_sel_in,
           load_size_in, load_unsigned_in, byte_offset_in, w_reg_en_in,
           w_reg_addr_in, rf_ready_in, query_addr_in,
    input  ready_out, reg_wr_en_out, reg_wr_addr_out, reg_data_out,
           hit_out, hit_data_out, retired_count_out
  );

  modport slave (
    input  valid_in, alu_data_in, mem_data_in, link_data_in, wb_sel_in,
           load_size_in, load_unsigned_in, byte_offset_in, w_reg_en_in,
           w_reg_addr_in, rf_ready_in, query_addr_in,
    output ready_out, reg_wr_en_out, reg_wr_addr_out, reg_data_out,
           hit_out, hit_data_out, retired_count_out
  );
endinterface : write_back_buffer_if
`default_nettype wire

// File: rtl/write_back_buffer_load_extend.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : write_back_buffer_load_extend (load_extend)                |
// | Brief   : Big-endian byte/half lane select with sign/zero extension. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module write_back_buffer_load_extend
  import write_back_buffer_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_offset,
  output logic [31:0] o_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[31:24];
    case (i_offset)
      2'd1:    w_byte = i_word[23:16];
      2'd2:    w_byte = i_word[15:8];
      2'd3:    w_byte = i_word[7:0];
      default: w_byte = i_word[31:24];
    endcase
    // Offset bit 0 is ignored for halves, so misaligned halves snap down.
    w_half = i_offset[1] ? i_word[15:0] : i_word[31:16];
  end

  always_comb begin
    o_data = i_word;
    case (i_size)
      LD_BYTE: o_data = i_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      LD_HALF: o_data = i_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: o_data = i_word;
    endcase
  end
endmodule : write_back_buffer_load_extend
`default_nettype wire

// File: rtl/write_back_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : write_back_buffer                                          |
// | Brief   : DLX write-back stage with a commit FIFO feeding the RF and |
// |           youngest-first forwarding lookup. Option: WB_LOAD_EXT_EN   |
// |           enables sub-word load alignment (needs DATA_WIDTH == 32).  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module write_back_buffer
  import write_back_buffer_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int BUF_DEPTH      = 2,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  write_back_buffer_if.slave  bus
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);

  logic [DATA_WIDTH-1:0]     r_data [BUF_DEPTH];
  logic [REG_ADDR_WIDTH-1:0] r_addr [BUF_DEPTH];
  logic [PTR_W-1:0]          r_rd_ptr;
  logic [PTR_W-1:0]          r_wr_ptr;
  logic [OCC_W-1:0]          r_occ;
  logic [COUNT_WIDTH-1:0]    r_count;

  logic [DATA_WIDTH-1:0]     w_mem_data;
  logic [DATA_WIDTH-1:0]     w_result;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_hit;
  logic [DATA_WIDTH-1:0]     w_hit_data;
  logic [PTR_W-1:0]          w_idx;

`ifdef WB_LOAD_EXT_EN
  write_back_buffer_load_extend u_load_extend (
    .i_word     (bus.mem_data_in),
    .i_size     (bus.load_size_in),
    .i_unsigned (bus.load_unsigned_in),
    .i_offset   (bus.byte_offset_in),
    .o_data     (w_mem_data)
  );
`else
  logic w_unused_ok;
  assign w_mem_data  = bus.mem_data_in;
  assign w_unused_ok = ^{bus.load_size_in, bus.load_unsigned_in, bus.byte_offset_in};
`endif

  always_comb begin
    w_result = bus.alu_data_in;
    case (bus.wb_sel_in)
      WB_SEL_MEM:  w_result = w_mem_data;
      WB_SEL_LINK: w_result = bus.link_data_in;
      default:     w_result = bus.alu_data_in;
    endcase
  end

  assign w_full  = (r_occ == OCC_W'(BUF_DEPTH));
  assign w_empty = (r_occ == '0);
  // Writes to r0 or with the enable low are accepted but never stored.
  assign w_push  = bus.valid_in && !w_full && bus.w_reg_en_in && (bus.w_reg_addr_in != '0);
  assign w_pop   = !w_empty && bus.rf_ready_in;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wr_ptr] <= w_result;
      r_addr[r_wr_ptr] <= bus.w_reg_addr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count  <= r_count + COUNT_WIDTH'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    w_idx      = r_rd_ptr;
    for (int k = 0; k < BUF_DEPTH; k++) begin
      w_idx = r_rd_ptr + PTR_W'(k);
      if ((OCC_W'(k) < r_occ) && (bus.query_addr_in != '0) &&
          (r_addr[w_idx] == bus.query_addr_in)) begin
        w_hit      = 1'b1;
        w_hit_data = r_data[w_idx];
      end
    end
  end

  assign bus.ready_out         = !w_full;
  assign bus.reg_wr_en_out     = !w_empty;
  assign bus.reg_wr_addr_out   = w_empty ? '0 : r_addr[r_rd_ptr];
  assign bus.reg_data_out      = w_empty ? '0 : r_data[r_rd_ptr];
  assign bus.hit_out           = w_hit;
  assign bus.hit_data_out      = w_hit_data;
  assign bus.retired_count_out = r_count;
endmodule : write_back_buffer
`default_nettype wire

// File: tb/tb_write_back_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_write_back_buffer                                       |
// | Brief   : Queue-model scoreboard plus directed literal checks.       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_write_back_buffer;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  write_back_buffer_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .COUNT_WIDTH(32)) bus ();

  write_back_buffer #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .BUF_DEPTH(DEPTH), .COUNT_WIDTH(32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result the spec rules say should be written, computed by shifting lanes.
  function automatic logic [31:0] model_result(input logic [1:0] sel, input logic [31:0] alu,
      input logic [31:0] mem, input logic [31:0] link, input logic [1:0] size,
      input logic uns, input logic [1:0] off);
    logic [31:0] lane;
    if (sel == 2'd2) return link;
    if (sel != 2'd1) return alu;
`ifdef WB_LOAD_EXT_EN
    if (size >= 2'd2) return mem;
    if (size == 2'd0) begin
      lane = (mem >> (8 * (3 - int'(off)))) & 32'hFF;
      return (uns || !lane[7]) ? lane : (lane | 32'hFFFF_FF00);
    end
    lane = (mem >> (16 * (1 - int'(off[1])))) & 32'hFFFF;
    return (uns || !lane[15]) ? lane : (lane | 32'hFFFF_0000);
`else
    lane = {30'd0, size} ^ {31'd0, uns} ^ {30'd0, off};
    return (lane == 32'hFFFF_FFFF) ? 32'd0 : mem;
`endif
  endfunction

  logic [4:0]  m_addr[$];
  logic [31:0] m_data[$];
  logic [31:0] m_count = 0;
  bit          model_on = 0;

  always @(posedge clk) begin
    bit          do_pop;
    bit          do_push;
    logic [31:0] d;
    model_on = 1;
    if (!rst_n) begin
      m_addr.delete();
      m_data.delete();
      m_count = 0;
    end else begin
      do_push = bus.valid_in && (m_addr.size() < DEPTH) && bus.w_reg_en_in &&
                (bus.w_reg_addr_in != 5'd0);
      do_pop  = (m_addr.size() > 0) && bus.rf_ready_in;
      d = model_result(bus.wb_sel_in, bus.alu_data_in, bus.mem_data_in, bus.link_data_in,
                       bus.load_size_in, bus.load_unsigned_in, bus.byte_offset_in);
      if (do_pop) begin
        void'(m_addr.pop_front());
        void'(m_data.pop_front());
        m_count++;
      end
      if (do_push) begin
        m_addr.push_back(bus.w_reg_addr_in);
        m_data.push_back(d);
      end
    end
  end

  always @(negedge clk) begin
    bit          e_hit;
    logic [31:0] e_hd;
    if (model_on) begin
      e_hit = 0;
      e_hd  = 0;
      for (int i = m_addr.size() - 1; i >= 0; i--) begin
        if (!e_hit && bus.query_addr_in != 5'd0 && m_addr[i] == bus.query_addr_in) begin
          e_hit = 1;
          e_hd  = m_data[i];
        end
      end
      check("m_ready", bus.ready_out, m_addr.size() < DEPTH);
      check("m_wr_en", bus.reg_wr_en_out, m_addr.size() > 0);
      check("m_wr_addr", bus.reg_wr_addr_out, (m_addr.size() > 0) ? m_addr[0] : 5'd0);
      check("m_wr_data", bus.reg_data_out, (m_data.size() > 0) ? m_data[0] : 32'd0);
      check("m_hit", bus.hit_out, e_hit);
      check("m_hit_data", bus.hit_data_out, e_hd);
      check("m_count", bus.retired_count_out, m_count);
    end
  end

  task automatic drive(input bit v, input logic [1:0] sel, input logic [31:0] alu,
      input logic [31:0] mem, input logic [1:0] size, input bit uns, input logic [1:0] off,
      input bit en, input logic [4:0] addr);
    bus.valid_in         = v;
    bus.wb_sel_in        = sel;
    bus.alu_data_in      = alu;
    bus.mem_data_in      = mem;
    bus.link_data_in     = 32'h0000_0100;
    bus.load_size_in     = size;
    bus.load_unsigned_in = uns;
    bus.byte_offset_in   = off;
    bus.w_reg_en_in      = en;
    bus.w_reg_addr_in    = addr;
  endtask

  task automatic push_alu(input logic [4:0] addr, input logic [31:0] data);
    drive(1, 2'd0, data, 32'h0, 2'd2, 0, 2'd0, 1, addr);
  endtask

  task automatic idle();
    drive(0, 2'd0, 32'h0, 32'h0, 2'd2, 0, 2'd0, 0, 5'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  size;
    bit          uns;
    logic [1:0]  off;
    logic [31:0] exp_ext;
    logic [31:0] exp_raw;
  } ld_vec_t;

  ld_vec_t ld_vecs[7] = '{
    '{2'd1, 2'd0, 0, 2'd0, 32'hFFFF_FF80, 32'h80FF_7F01},
    '{2'd1, 2'd1, 1, 2'd2, 32'h0000_7F01, 32'h80FF_7F01},
    '{2'd1, 2'd1, 0, 2'd0, 32'hFFFF_80FF, 32'h80FF_7F01},
    '{2'd1, 2'd0, 1, 2'd1, 32'h0000_00FF, 32'h80FF_7F01},
    '{2'd1, 2'd1, 0, 2'd1, 32'hFFFF_80FF, 32'h80FF_7F01},
    '{2'd2, 2'd0, 0, 2'd0, 32'h0000_0100, 32'h0000_0100},
    '{2'd3, 2'd0, 0, 2'd0, 32'hAAAA_0000, 32'hAAAA_0000}
  };

  initial begin
    logic [31:0] exp;
    idle();
    bus.rf_ready_in   = 1'b1;
    bus.query_addr_in = 5'd0;
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_ready", bus.ready_out, 1'b1);
    check("rst_wr_en", bus.reg_wr_en_out, 1'b0);
    check("rst_wr_data", bus.reg_data_out, 32'h0);
    check("rst_count", bus.retired_count_out, 32'd0);

    rst_n = 1'b1;
    push_alu(5'd5, 32'h1234_5678);
    step();
    check("alu_wr_en", bus.reg_wr_en_out, 1'b1);
    check("alu_wr_addr", bus.reg_wr_addr_out, 5'd5);
    check("alu_wr_data", bus.reg_data_out, 32'h1234_5678);
    idle();
    step();
    check("alu_count", bus.retired_count_out, 32'd1);
    check("alu_drained", bus.reg_wr_en_out, 1'b0);

    foreach (ld_vecs[i]) begin
      drive(1, ld_vecs[i].sel, 32'hAAAA_0000, 32'h80FF_7F01, ld_vecs[i].size,
            ld_vecs[i].uns, ld_vecs[i].off, 1, 5'd3);
      step();
`ifdef WB_LOAD_EXT_EN
      exp = ld_vecs[i].exp_ext;
`else
      exp = ld_vecs[i].exp_raw;
`endif
      check($sformatf("ld_data[%0d]", i), bus.reg_data_out, exp);
      idle();
      step();
    end
    check("ld_count", bus.retired_count_out, 32'd8);

    push_alu(5'd0, 32'hDEAD_BEEF);
    step();
    check("r0_wr_en", bus.reg_wr_en_out, 1'b0);
    drive(1, 2'd0, 32'hCAFE_F00D, 32'h0, 2'd2, 0, 2'd0, 0, 5'd9);
    step();
    check("noen_wr_en", bus.reg_wr_en_out, 1'b0);
    check("discard_count", bus.retired_count_out, 32'd8);

    bus.rf_ready_in = 1'b0;
    push_alu(5'd1, 32'h11);
    step();
    check("bp_ready1", bus.ready_out, 1'b1);
    push_alu(5'd2, 32'h22);
    step();
    check("bp_full", bus.ready_out, 1'b0);
    push_alu(5'd3, 32'h33);
    step();
    check("bp_hold_ready", bus.ready_out, 1'b0);
    check("bp_hold_addr", bus.reg_wr_addr_out, 5'd1);
    check("bp_hold_data", bus.reg_data_out, 32'h11);
    bus.rf_ready_in = 1'b1;
    step();
    check("bp_drain1", bus.reg_wr_addr_out, 5'd2);
    check("bp_ready2", bus.ready_out, 1'b1);
    step();
    check("bp_drain2", bus.reg_wr_addr_out, 5'd3);
    check("bp_drain2_data", bus.reg_data_out, 32'h33);
    idle();
    step();
    check("bp_empty", bus.reg_wr_en_out, 1'b0);
    check("bp_count", bus.retired_count_out, 32'd11);

    bus.rf_ready_in = 1'b0;
    push_alu(5'd7, 32'hA);
    step();
    push_alu(5'd7, 32'hB);
    bus.query_addr_in = 5'd7;
    #1;
    check("hit_same_cycle", bus.hit_data_out, 32'hA);
    step();
    idle();
    #1;
    check("hit_youngest", bus.hit_out, 1'b1);
    check("hit_youngest_data", bus.hit_data_out, 32'hB);
    bus.query_addr_in = 5'd8;
    #1;
    check("miss_hit", bus.hit_out, 1'b0);
    check("miss_data", bus.hit_data_out, 32'h0);
    bus.query_addr_in = 5'd0;
    #1;
    check("r0_query", bus.hit_out, 1'b0);
    bus.query_addr_in = 5'd7;
    step();

    rst_n = 1'b0;
    step();
    check("mid_rst_wr_en", bus.reg_wr_en_out, 1'b0);
    check("mid_rst_ready", bus.ready_out, 1'b1);
    check("mid_rst_count", bus.retired_count_out, 32'd0);
    check("mid_rst_hit", bus.hit_out, 1'b0);
    rst_n = 1'b1;
    bus.rf_ready_in = 1'b1;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule : tb_write_back_buffer
`default_nettype wire
